// File: rtl/fsab_arbiter.sv
// fsab_arbiter: shares one FSAB master port between two req/ack clients.
// Owns the credit pool, round-robins headers, locks the bus for write bursts, steers fsabi by DID.
module fsab_arbiter #(
    parameter int unsigned FSAB_REQ_HI          = 0,
    parameter int unsigned FSAB_DID_HI          = 4,
    parameter int unsigned FSAB_SUBDID_HI       = 4,
    parameter int unsigned FSAB_ADDR_HI         = 30,
    parameter int unsigned FSAB_LEN_HI          = 2,
    parameter int unsigned FSAB_DATA_HI         = 63,
    parameter int unsigned FSAB_MASK_HI         = 7,
    parameter int unsigned FSAB_CREDITS_HI      = 2,
    parameter int unsigned FSAB_INITIAL_CREDITS = 4,
    parameter int unsigned FSAB_READ            = 0,
    parameter int unsigned FSAB_WRITE           = 1,
    parameter int unsigned C0_DID               = 0,
    parameter int unsigned C1_DID               = 1
) (
    input  logic                      clk,
    input  logic                      Nrst,

    input  logic                      c0_req,
    input  logic [FSAB_REQ_HI:0]      c0_mode,
    input  logic [FSAB_SUBDID_HI:0]   c0_subdid,
    input  logic [FSAB_ADDR_HI:0]     c0_addr,
    input  logic [FSAB_LEN_HI:0]      c0_len,
    input  logic [FSAB_DATA_HI:0]     c0_data,
    input  logic [FSAB_MASK_HI:0]     c0_mask,
    output logic                      c0_ack,
    output logic                      c0_fsabi_valid,

    input  logic                      c1_req,
    input  logic [FSAB_REQ_HI:0]      c1_mode,
    input  logic [FSAB_SUBDID_HI:0]   c1_subdid,
    input  logic [FSAB_ADDR_HI:0]     c1_addr,
    input  logic [FSAB_LEN_HI:0]      c1_len,
    input  logic [FSAB_DATA_HI:0]     c1_data,
    input  logic [FSAB_MASK_HI:0]     c1_mask,
    output logic                      c1_ack,
    output logic                      c1_fsabi_valid,

    output logic                      fsabo_valid,
    output logic [FSAB_REQ_HI:0]      fsabo_mode,
    output logic [FSAB_DID_HI:0]      fsabo_did,
    output logic [FSAB_SUBDID_HI:0]   fsabo_subdid,
    output logic [FSAB_ADDR_HI:0]     fsabo_addr,
    output logic [FSAB_LEN_HI:0]      fsabo_len,
    output logic [FSAB_DATA_HI:0]     fsabo_data,
    output logic [FSAB_MASK_HI:0]     fsabo_mask,
    input  logic                      fsabo_credit,

    input  logic                      fsabi_valid,
    input  logic [FSAB_DID_HI:0]      fsabi_did,
    input  logic [FSAB_SUBDID_HI:0]   fsabi_subdid,
    input  logic [FSAB_DATA_HI:0]     fsabi_data,
    output logic [FSAB_SUBDID_HI:0]   fsabi_subdid_o,
    output logic [FSAB_DATA_HI:0]     fsabi_data_o
);

    localparam int unsigned CR_W   = FSAB_CREDITS_HI + 1;
    localparam int unsigned LEN_W  = FSAB_LEN_HI + 1;
    localparam int unsigned MODE_W = FSAB_REQ_HI + 1;
    localparam int unsigned DID_W  = FSAB_DID_HI + 1;

    localparam logic [CR_W-1:0]   CR_INIT = CR_W'(FSAB_INITIAL_CREDITS);
    localparam logic [MODE_W-1:0] MODE_RD = MODE_W'(FSAB_READ);
    localparam logic [MODE_W-1:0] MODE_WR = MODE_W'(FSAB_WRITE);
    localparam logic [DID_W-1:0]  DID0    = DID_W'(C0_DID);
    localparam logic [DID_W-1:0]  DID1    = DID_W'(C1_DID);
    localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);

    typedef enum logic [0:0] {
        S_IDLE,
        S_WBURST
    } state_t;

    state_t                  r_state;
    logic [CR_W-1:0]         r_credits;
    logic                    r_last;
    logic                    r_owner;
    logic [LEN_W-1:0]        r_rem;

    logic                    w_idle;
    logic                    w_can_hdr;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_bst0;
    logic                    w_bst1;
    logic                    w_hdr;
    logic                    w_beat;
    logic                    w_sel;
    logic [MODE_W-1:0]       w_mode;
    logic [FSAB_SUBDID_HI:0] w_subdid;
    logic [FSAB_ADDR_HI:0]   w_addr;
    logic [LEN_W-1:0]        w_len;
    logic [FSAB_DATA_HI:0]   w_data;
    logic [FSAB_MASK_HI:0]   w_mask;
    logic [DID_W-1:0]        w_did;
    logic [CR_W-1:0]         w_credits_nxt;

    // Header grants use the registered credit count; a tie goes to the client not granted last.
    always_comb begin
        w_idle    = (r_state == S_IDLE);
        w_can_hdr = w_idle && (r_credits != '0);
        w_gnt0    = w_can_hdr && c0_req && (!c1_req || r_last);
        w_gnt1    = w_can_hdr && c1_req && (!c0_req || !r_last);
        w_bst0    = !w_idle && !r_owner && c0_req;
        w_bst1    = !w_idle &&  r_owner && c1_req;
        w_hdr     = w_gnt0 || w_gnt1;
        w_beat    = w_bst0 || w_bst1;
        w_sel     = w_gnt1 || w_bst1;
    end

    always_comb begin
        w_mode   = w_sel ? c1_mode   : c0_mode;
        w_subdid = w_sel ? c1_subdid : c0_subdid;
        w_addr   = w_sel ? c1_addr   : c0_addr;
        w_len    = w_sel ? c1_len    : c0_len;
        w_data   = w_sel ? c1_data   : c0_data;
        w_mask   = w_sel ? c1_mask   : c0_mask;
        w_did    = w_sel ? DID1      : DID0;
    end

    always_comb begin
        w_credits_nxt = r_credits;
        if (w_hdr && !fsabo_credit) begin
            w_credits_nxt = r_credits - 1'b1;
        end else if (fsabo_credit && !w_hdr) begin
            w_credits_nxt = r_credits + 1'b1;
        end
    end

    assign c0_ack = Nrst && (w_gnt0 || w_bst0);
    assign c1_ack = Nrst && (w_gnt1 || w_bst1);

    assign c0_fsabi_valid = fsabi_valid && (fsabi_did == DID0);
    assign c1_fsabi_valid = fsabi_valid && (fsabi_did == DID1);
    assign fsabi_subdid_o = fsabi_subdid;
    assign fsabi_data_o   = fsabi_data;

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            r_state      <= S_IDLE;
            r_credits    <= CR_INIT;
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            r_rem        <= '0;
            fsabo_valid  <= 1'b0;
            fsabo_mode   <= '0;
            fsabo_did    <= '0;
            fsabo_subdid <= '0;
            fsabo_addr   <= '0;
            fsabo_len    <= '0;
            fsabo_data   <= '0;
            fsabo_mask   <= '0;
        end else begin
            r_credits   <= w_credits_nxt;
            fsabo_valid <= w_hdr || w_beat;
            if (w_hdr || w_beat) begin
                fsabo_data <= w_data;
                fsabo_mask <= w_mask;
            end
            // Burst data beats leave the header fields holding the burst's header.
            if (w_hdr) begin
                fsabo_mode   <= w_mode;
                fsabo_did    <= w_did;
                fsabo_subdid <= w_subdid;
                fsabo_addr   <= w_addr;
                fsabo_len    <= w_len;
                r_last       <= w_sel;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_hdr && (w_mode == MODE_WR) && (w_len > LEN_ONE)) begin
                        r_state <= S_WBURST;
                        r_owner <= w_sel;
                        r_rem   <= w_len - LEN_ONE;
                    end
                end
                S_WBURST: begin
                    if (w_beat) begin
                        r_rem <= r_rem - LEN_ONE;
                        if (r_rem == LEN_ONE) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Nrst) begin
            if (fsabo_credit && !w_hdr) begin
                assert (r_credits != CR_INIT)
                    else $error("fsab_arbiter: credit return beyond initial pool");
            end
            if (w_hdr && !fsabo_credit) begin
                assert (r_credits != '0)
                    else $error("fsab_arbiter: credit pool underflow");
            end
            if (w_hdr) begin
                assert ((w_mode == MODE_RD) || (w_mode == MODE_WR))
                    else $error("fsab_arbiter: unknown request mode");
            end
            if (fsabi_valid) begin
                assert ((fsabi_did == DID0) || (fsabi_did == DID1))
                    else $error("fsab_arbiter: fsabi beat with unknown DID dropped");
            end
        end
    end

endmodule
